// File: rtl/multi_button_pulser.sv
// multi_button_pulser: per-channel sync + debounce, press strobe,
// hold pause and accelerating auto-repeat strobes.
module multi_button_pulser #(
  parameter int N_CH            = 4,
  parameter int CLOCK_PERIOD_NS = 20,
  parameter int DEBOUNCE_NS     = 10_000_000,
  parameter int PAUSE_NS        = 250_000_000,
  parameter int REPEAT_NS       = 150_000_000,
  parameter int FAST_REPEAT_NS  = 50_000_000,
  parameter int ACCEL_COUNT     = 8,
  parameter logic [N_CH-1:0] ACTIVE_LOW = {N_CH{1'b1}}
) (
  input  logic            clk_i,
  input  logic            nReset_i,
  input  logic [N_CH-1:0] btn_i,
  input  logic [N_CH-1:0] repeat_en_i,
  output logic [N_CH-1:0] strobe_o,
  output logic [N_CH-1:0] held_o,
  output logic [N_CH-1:0] repeating_o
);

  function automatic int to_cyc(input int ns);
    int c;
    c = ns / CLOCK_PERIOD_NS;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DEB_CYC   = to_cyc(DEBOUNCE_NS);
  localparam int PAUSE_CYC = to_cyc(PAUSE_NS);
  localparam int REP_CYC   = to_cyc(REPEAT_NS);
  localparam int FAST_CYC  = to_cyc(FAST_REPEAT_NS);
  localparam int MAX_CYC   = max2(max2(DEB_CYC, PAUSE_CYC),
                                  max2(REP_CYC, FAST_CYC));
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam int TW = (ACCEL_COUNT < 1) ? 1 : $clog2(ACCEL_COUNT + 1);

  localparam logic [CW-1:0] DEB_C   = CW'(DEB_CYC);
  localparam logic [CW-1:0] PAUSE_C = CW'(PAUSE_CYC);
  localparam logic [CW-1:0] REP_C   = CW'(REP_CYC);
  localparam logic [CW-1:0] FAST_C  = CW'(FAST_CYC);
  localparam logic [TW-1:0] ACC_C   = TW'(ACCEL_COUNT);
  localparam logic [TW-1:0] ACC_M1  = TW'(ACCEL_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAUSE,
    S_REPEAT,
    S_FAST
  } state_t;

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [N_CH-1:0] w_pressed;

  // Synchronisers idle at the raw released level of each channel.
  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = r_sync2 ^ ACTIVE_LOW;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic          r_deb;
    logic [CW-1:0] r_dcnt;
    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [TW-1:0] r_tally;
    logic [TW-1:0] w_tally_nx;
    logic          r_lock;
    logic          w_lock_nx;
    logic          r_strobe;
    logic          w_strobe_nx;

    always_ff @(posedge clk_i or negedge nReset_i) begin
      if (!nReset_i) begin
        r_deb  <= 1'b0;
        r_dcnt <= '0;
      end else if (w_pressed[g] == r_deb) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DEB_C) begin
        r_deb  <= ~r_deb;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + CW'(1);
      end
    end

    always_ff @(posedge clk_i or negedge nReset_i) begin
      if (!nReset_i) begin
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_tally  <= '0;
        r_lock   <= 1'b0;
        r_strobe <= 1'b0;
      end else begin
        r_state  <= w_state_nx;
        r_cnt    <= w_cnt_nx;
        r_tally  <= w_tally_nx;
        r_lock   <= w_lock_nx;
        r_strobe <= w_strobe_nx;
      end
    end

    // r_lock parks a held channel in PAUSE until release.
    always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_tally_nx  = r_tally;
      w_lock_nx   = r_lock;
      w_strobe_nx = 1'b0;
      if (!r_deb) begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
        w_tally_nx = '0;
        w_lock_nx  = 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            w_strobe_nx = 1'b1;
            w_cnt_nx    = '0;
            w_state_nx  = S_PAUSE;
          end
          S_PAUSE: begin
            if (!r_lock) begin
              if (r_cnt != PAUSE_C) begin
                w_cnt_nx = r_cnt + CW'(1);
              end else if (repeat_en_i[g]) begin
                w_strobe_nx = 1'b1;
                w_cnt_nx    = '0;
                w_tally_nx  = '0;
                w_state_nx  = S_REPEAT;
              end else begin
                w_lock_nx = 1'b1;
              end
            end
          end
          S_REPEAT: begin
            if (!repeat_en_i[g]) begin
              w_state_nx = S_PAUSE;
              w_cnt_nx   = PAUSE_C;
              w_lock_nx  = 1'b1;
            end else if (r_cnt != REP_C) begin
              w_cnt_nx = r_cnt + CW'(1);
            end else begin
              w_strobe_nx = 1'b1;
              w_cnt_nx    = '0;
              if (r_tally != ACC_C) begin
                w_tally_nx = r_tally + TW'(1);
                if (r_tally == ACC_M1) begin
                  w_state_nx = S_FAST;
                end
              end
            end
          end
          S_FAST: begin
            if (!repeat_en_i[g]) begin
              w_state_nx = S_PAUSE;
              w_cnt_nx   = PAUSE_C;
              w_lock_nx  = 1'b1;
            end else if (r_cnt != FAST_C) begin
              w_cnt_nx = r_cnt + CW'(1);
            end else begin
              w_strobe_nx = 1'b1;
              w_cnt_nx    = '0;
            end
          end
        endcase
      end
    end

    assign strobe_o[g]    = r_strobe;
    assign held_o[g]      = r_deb;
    assign repeating_o[g] = (r_state == S_REPEAT) ||
                            (r_state == S_FAST);
  end

endmodule
